alu_result_fifo: RTL and testbench

Downstream stage of the 3-bit ALU. Captures each 4-bit ALU result and its opcode into a small FIFO with valid/ready handshakes on both sides. Computes zero and carry flags at capture time. Decouples the ALU from a consumer that may stall.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_flag_gen.sv | 18 +
 rtl/alu_result_fifo.sv | 119 +++++++++++
 tb/tb_alu_result_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the result-entry record
// carried by downstream consumers of the 3-bit ALU.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 2;

  localparam logic [ALU_OP_W-1:0] OP_AND = 2'b00;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 2'b01;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 2'b10;
  localparam logic [ALU_OP_W-1:0] OP_NOT = 2'b11;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_OP_W-1:0]   op;
    logic                  zero;
    logic                  carry;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/carry flag generator for an ALU result; carry is the result MSB,
// meaningful only for ADD.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic [DATA_W-1:0] i_result,
  input  logic [OP_W-1:0]   i_op,
  output logic              o_zero,
  output logic              o_carry
);

  assign o_zero  = (i_result == '0);
  assign o_carry = (i_op == OP_W'(OP_ADD)) && i_result[DATA_W-1];

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU: stores {result, op, zero, carry} with valid/ready on both sides.
// Define ALU_RESULT_STATS_EN to add the saturating zero_pops counter output.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = ALU_DATA_W,
  parameter  int OP_W   = ALU_OP_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [OP_W-1:0]   out_op,
  output logic              out_zero,
  output logic              out_carry,
  output logic [PTR_W:0]    level
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [7:0]        zero_pops
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [OP_W-1:0]   op;
    logic              zero;
    logic              carry;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  logic   w_zero;
  logic   w_carry;
  entry_t w_entry;
  entry_t w_head;

  alu_flag_gen #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_flag_gen (
    .i_result (in_result),
    .i_op     (in_op),
    .o_zero   (w_zero),
    .o_carry  (w_carry)
  );

  // Handshake status depends only on the registered count, never on the partner's signal.
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign w_entry = '{result: in_result, op: in_op, zero: w_zero, carry: w_carry};

  // NOTE: storage is deliberately left out of reset; the empty gating on the outputs
  // hides stale contents, and keeping it reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_result = w_empty ? '0   : w_head.result;
  assign out_op     = w_empty ? '0   : w_head.op;
  assign out_zero   = w_empty ? 1'b0 : w_head.zero;
  assign out_carry  = w_empty ? 1'b0 : w_head.carry;
  assign level      = r_count;

`ifdef ALU_RESULT_STATS_EN
  logic [7:0] r_zero_pops;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero_pops <= '0;
    end else if (w_pop && w_head.zero && (r_zero_pops != 8'hFF)) begin
      r_zero_pops <= r_zero_pops + 8'd1;
    end
  end

  assign zero_pops = r_zero_pops;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: accepted pushes queue a model entry, a negedge
// monitor compares every popped head against it in order.
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] result;
    logic [1:0] op;
    logic       zero;
    logic       carry;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_result = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [1:0] out_op;
  logic       out_zero;
  logic       out_carry;
  logic [2:0] level;
`ifdef ALU_RESULT_STATS_EN
  logic [7:0] zero_pops;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .level      (level)
`ifdef ALU_RESULT_STATS_EN
    ,
    .zero_pops  (zero_pops)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] r, input logic [1:0] op);
    exp_t e;
    e.result = r;
    e.op     = op;
    e.zero   = (r == 4'd0);
    e.carry  = (op == 2'b10) && r[3];
    return e;
  endfunction

  // Output check runs before the push so an entry never meets itself in the same cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", 32'(out_result), 32'(e.result));
          check("sb_op",     32'(out_op),     32'(e.op));
          check("sb_zero",   32'(out_zero),   32'(e.zero));
          check("sb_carry",  32'(out_carry),  32'(e.carry));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_result, in_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] r, input logic [1:0] op);
    in_valid  = 1'b1;
    in_result = r;
    in_op     = op;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && out_valid; i++) tick();
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset then idle
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_level",      32'(level),      32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_op",     32'(out_op),     32'd0);
    check("rst_out_zero",   32'(out_zero),   32'd0);
    check("rst_out_carry",  32'(out_carry),  32'd0);

    // 2: single ADD push, visible the cycle after the edge
    push_one(4'b1010, OP_ADD);
    check("t2_out_valid",  32'(out_valid),  32'd1);
    check("t2_out_result", 32'(out_result), 32'hA);
    check("t2_out_carry",  32'(out_carry),  32'd1);
    check("t2_out_zero",   32'(out_zero),   32'd0);
    check("t2_level",      32'(level),      32'd1);
    drain();

    // 3: fill, overflow attempt ignored, drain in order
    push_one(4'd0, OP_OR);
    push_one(4'd7, OP_AND);
    push_one(4'd8, OP_NOT);
    push_one(4'd3, OP_ADD);
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    check("t3_level_full",    32'(level),    32'd4);
    push_one(4'd5, OP_OR);
    check("t3_level_after_5th", 32'(level),      32'd4);
    check("t3_head_result",     32'(out_result), 32'd0);
    check("t3_head_zero",       32'(out_zero),   32'd1);
    check("t3_head_op",         32'(out_op),     32'(OP_OR));
    drain();

    // 4: full with simultaneous push and pop: push blocked, pop proceeds
    push_one(4'd1, OP_ADD);
    push_one(4'd2, OP_AND);
    push_one(4'd12, OP_ADD);
    push_one(4'd4, OP_OR);
    in_valid  = 1'b1;
    in_result = 4'd9;
    in_op     = OP_AND;
    out_ready = 1'b1;
    check("t4_in_ready_full", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    check("t4_level_after_pop", 32'(level),    32'd3);
    check("t4_in_ready_rises",  32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_level_after_push", 32'(level), 32'd4);
    drain();

    // 5: streaming at level 1, values 0..9 with ADD
    push_one(4'd0, OP_ADD);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_op     = OP_ADD;
    for (int i = 1; i < 10; i++) begin
      in_result = 4'(i);
      if (i == 9) check("t5_carry_at_8", 32'(out_carry), 32'd1);
      tick();
      check("t5_level", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    check("t5_carry_at_9", 32'(out_carry), 32'd1);
    tick();
    out_ready = 1'b0;
    check("t5_level_end", 32'(level), 32'd0);

    // 6: asynchronous reset mid-cycle while level=3
    push_one(4'd6, OP_OR);
    push_one(4'd0, OP_AND);
    push_one(4'd11, OP_ADD);
    check("t6_level_pre", 32'(level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_level_async",     32'(level),      32'd0);
    check("t6_out_valid_async", 32'(out_valid),  32'd0);
    check("t6_out_result",      32'(out_result), 32'd0);
    check("t6_in_ready",        32'(in_ready),   32'd1);
    tick();
    rst = 1'b0;
    tick();
`ifdef ALU_RESULT_STATS_EN
    check("t6_zero_pops_rst", 32'(zero_pops), 32'd0);
    push_one(4'd0, OP_AND);
    in_valid  = 1'b1;
    in_result = 4'd0;
    in_op     = OP_OR;
    out_ready = 1'b1;
    repeat (5) tick();
    check("t6_zero_pops_5", 32'(zero_pops), 32'd5);
    repeat (295) tick();
    check("t6_zero_pops_sat", 32'(zero_pops), 32'hFF);
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t6_zero_pops_hold", 32'(zero_pops), 32'hFF);
`endif
    check("end_level",   32'(level),        32'd0);
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
